// File: rtl/img_disp_engine.sv
`default_nettype none
// ============================================================================
// Module   : img_disp_engine
// Purpose  : Maps VGA beam coordinates onto a scaled, rotatable, invertible
//            tile image in an external ROM, with frame-synchronous commands.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module img_disp_engine #(
    parameter int N_IMG       = 4,
    parameter int TB          = 4,
    parameter int SCALE_LOG2  = 3,
    parameter int ORG_X       = 192,
    parameter int ORG_Y       = 112,
    parameter int AUTO_FRAMES = 60,
    parameter int ROM_LAT     = 0,
    parameter int CW          = 3,
    parameter int BG_COLOR    = 0,
    localparam int IW         = (N_IMG > 2) ? $clog2(N_IMG) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step_fwd,
    input  logic          step_back,
    input  logic          rotate,
    input  logic          inverse,
    input  logic          auto_en,
    input  logic [9:0]    hc,
    input  logic [9:0]    vc,
    input  logic          disp_on,
    input  logic          hsync_in,
    input  logic          vsync_in,
    output logic [IW-1:0] rom_img,
    output logic [TB-1:0] rom_x,
    output logic [TB-1:0] rom_y,
    input  logic [CW-1:0] rom_color,
    output logic [CW-1:0] color,
    output logic          hsync,
    output logic          vsync,
    output logic [IW-1:0] cur_img,
    output logic [1:0]    cur_rot,
    output logic          cur_inv
);

    localparam int c_L      = 2 + ROM_LAT;
    localparam int c_PW     = ROM_LAT + 1;
    localparam int c_SPAN   = 1 << (TB + SCALE_LOG2);
    localparam int c_SUM_W  = IW + 2;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_BACK = 2'd2
    } step_t;

    logic          r_prev_fwd, r_prev_back, r_prev_rot, r_prev_inv;
    logic          w_ev_fwd, w_ev_back, w_ev_rot, w_ev_inv;
    step_t         r_pend_step, w_step_base, w_pend_step_nxt;
    logic [1:0]    r_pend_rot;
    logic          r_pend_inv;
    logic [9:0]    r_frame_cnt;
    logic [IW-1:0] r_cur_img, w_img_nxt;
    logic [1:0]    r_cur_rot;
    logic          r_cur_inv;
    logic          w_frame_tick, w_auto_fire;
    logic [c_SUM_W-1:0] w_img_sum;

    assign w_ev_fwd     = step_fwd  & ~r_prev_fwd;
    assign w_ev_back    = step_back & ~r_prev_back;
    assign w_ev_rot     = rotate    & ~r_prev_rot;
    assign w_ev_inv     = inverse   & ~r_prev_inv;
    assign w_frame_tick = (hc == 10'd0) && (vc == 10'd0);
    assign w_auto_fire  = w_frame_tick && auto_en && (r_frame_cnt == 10'(AUTO_FRAMES - 1));

    // Pending step restarts from empty on the tick so a same-cycle press survives.
    always_comb begin
        w_step_base     = w_frame_tick ? STEP_NONE : r_pend_step;
        w_pend_step_nxt = w_step_base;
        if (w_ev_fwd && w_ev_back)
            w_pend_step_nxt = STEP_NONE;
        else if (w_ev_fwd)
            w_pend_step_nxt = (w_step_base == STEP_BACK) ? STEP_NONE : STEP_FWD;
        else if (w_ev_back)
            w_pend_step_nxt = (w_step_base == STEP_FWD) ? STEP_NONE : STEP_BACK;
    end

    // Biased by N_IMG so a backward step never underflows; result lies in [N-1, 2N+1].
    always_comb begin
        w_img_sum = c_SUM_W'(r_cur_img) + c_SUM_W'(N_IMG);
        if (r_pend_step == STEP_FWD)
            w_img_sum = w_img_sum + c_SUM_W'(1);
        if (r_pend_step == STEP_BACK)
            w_img_sum = w_img_sum - c_SUM_W'(1);
        if (w_auto_fire)
            w_img_sum = w_img_sum + c_SUM_W'(1);
        if (w_img_sum >= c_SUM_W'(2 * N_IMG))
            w_img_nxt = IW'(w_img_sum - c_SUM_W'(2 * N_IMG));
        else if (w_img_sum >= c_SUM_W'(N_IMG))
            w_img_nxt = IW'(w_img_sum - c_SUM_W'(N_IMG));
        else
            w_img_nxt = IW'(w_img_sum);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev_fwd  <= 1'b0;
            r_prev_back <= 1'b0;
            r_prev_rot  <= 1'b0;
            r_prev_inv  <= 1'b0;
            r_pend_step <= STEP_NONE;
            r_pend_rot  <= 2'd0;
            r_pend_inv  <= 1'b0;
            r_frame_cnt <= 10'd0;
            r_cur_img   <= '0;
            r_cur_rot   <= 2'd0;
            r_cur_inv   <= 1'b0;
        end else begin
            r_prev_fwd  <= step_fwd;
            r_prev_back <= step_back;
            r_prev_rot  <= rotate;
            r_prev_inv  <= inverse;
            r_pend_step <= w_pend_step_nxt;
            if (w_frame_tick) begin
                r_cur_img  <= w_img_nxt;
                r_cur_rot  <= r_cur_rot + r_pend_rot;
                r_cur_inv  <= r_cur_inv ^ r_pend_inv;
                r_pend_rot <= {1'b0, w_ev_rot};
                r_pend_inv <= w_ev_inv;
            end else begin
                r_pend_rot <= r_pend_rot + {1'b0, w_ev_rot};
                r_pend_inv <= r_pend_inv ^ w_ev_inv;
            end
            if (!auto_en || w_ev_fwd || w_ev_back)
                r_frame_cnt <= 10'd0;
            else if (w_frame_tick)
                r_frame_cnt <= w_auto_fire ? 10'd0 : r_frame_cnt + 10'd1;
        end
    end

    logic [TB-1:0] w_u, w_v, w_x, w_y;
    logic          w_in_win;

    assign w_u = TB'((hc - 10'(ORG_X)) >> SCALE_LOG2);
    assign w_v = TB'((vc - 10'(ORG_Y)) >> SCALE_LOG2);
    assign w_in_win = disp_on
                   && (32'(hc) >= ORG_X) && (32'(hc) < ORG_X + c_SPAN)
                   && (32'(vc) >= ORG_Y) && (32'(vc) < ORG_Y + c_SPAN);

    // M - u is the bitwise complement for a power-of-two tile.
    always_comb begin
        w_x = w_u;
        w_y = w_v;
        case (r_cur_rot)
            2'd1:    begin w_x = w_v;  w_y = ~w_u; end
            2'd2:    begin w_x = ~w_u; w_y = ~w_v; end
            2'd3:    begin w_x = ~w_v; w_y = w_u;  end
            default: begin w_x = w_u;  w_y = w_v;  end
        endcase
    end

    logic [c_PW-1:0] r_win_pipe, r_disp_pipe, r_inv_pipe;
    logic [c_L-1:0]  r_hs_pipe, r_vs_pipe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_x       <= '0;
            rom_y       <= '0;
            rom_img     <= '0;
            r_win_pipe  <= '0;
            r_disp_pipe <= '0;
            r_inv_pipe  <= '0;
            r_hs_pipe   <= '1;
            r_vs_pipe   <= '1;
            color       <= '0;
        end else begin
            rom_x       <= w_x;
            rom_y       <= w_y;
            rom_img     <= r_cur_img;
            r_win_pipe  <= (r_win_pipe  << 1) | c_PW'(w_in_win);
            r_disp_pipe <= (r_disp_pipe << 1) | c_PW'(disp_on);
            r_inv_pipe  <= (r_inv_pipe  << 1) | c_PW'(r_cur_inv);
            r_hs_pipe   <= {r_hs_pipe[c_L-2:0], hsync_in};
            r_vs_pipe   <= {r_vs_pipe[c_L-2:0], vsync_in};
            if (r_win_pipe[ROM_LAT])
                color <= rom_color ^ {CW{r_inv_pipe[ROM_LAT]}};
            else if (r_disp_pipe[ROM_LAT])
                color <= CW'(BG_COLOR);
            else
                color <= '0;
        end
    end

    assign hsync   = r_hs_pipe[c_L-1];
    assign vsync   = r_vs_pipe[c_L-1];
    assign cur_img = r_cur_img;
    assign cur_rot = r_cur_rot;
    assign cur_inv = r_cur_inv;

endmodule
`default_nettype wire
